// File: rtl/mem_ctrl_pkg.sv
// Shared constants, size encodings and sequencer state codes for mem_ctrl.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_LEN = 32;
    localparam int unsigned DEF_DATA_LEN = 32;
    localparam int unsigned CNT_W        = 3;

    localparam logic [31:0] DEF_IO_ADDR_BASE = 32'h0003_0000;
    localparam int unsigned IO_WINDOW_BYTES  = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        STATUS_IDLE  = 2'd0,
        STATUS_READ  = 2'd1,
        STATUS_WRITE = 2'd2,
        STATUS_DONE  = 2'd3
    } status_e;

    // Byte count of an access; the reserved encoding is treated as a word.
    function automatic logic [CNT_W-1:0] size_to_len(input logic [1:0] size);
        logic [CNT_W-1:0] len;
        case (size)
            SIZE_B:  len = CNT_W'(1);
            SIZE_H:  len = CNT_W'(2);
            SIZE_W:  len = CNT_W'(4);
            default: len = CNT_W'(4);
        endcase
        return len;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: latches IF/LSB requests and serialises them onto a byte-wide RAM.
// Optional MEM_CTRL_IO_STALL_EN holds IO-window stores in IDLE while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_LEN     = DEF_ADDR_LEN,
    parameter int unsigned           DATA_LEN     = DEF_DATA_LEN,
    parameter logic [ADDR_LEN-1:0]   IO_ADDR_BASE = ADDR_LEN'(DEF_IO_ADDR_BASE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                ena_from_if,
    input  logic [ADDR_LEN-1:0] pc_from_if,
    input  logic                drop_flag_from_if,
    output logic                ok_flag_to_if,
    output logic [DATA_LEN-1:0] inst_to_if,
    input  logic                ena_from_lsb,
    input  logic                wr_from_lsb,
    input  logic [ADDR_LEN-1:0] addr_from_lsb,
    input  logic [1:0]          size_from_lsb,
    input  logic [DATA_LEN-1:0] data_from_lsb,
    input  logic                rollback_from_rob,
    output logic                ok_flag_to_lsb,
    output logic [DATA_LEN-1:0] data_to_lsb,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [ADDR_LEN-1:0] mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full
);

    logic                r_if_pend;
    logic [ADDR_LEN-1:0] r_if_addr;
    logic                r_lsb_pend;
    logic                r_lsb_wr;
    logic [ADDR_LEN-1:0] r_lsb_addr;
    logic [1:0]          r_lsb_size;
    logic [DATA_LEN-1:0] r_lsb_data;

    status_e             r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]    r_len, w_len_nx;
    logic [ADDR_LEN-1:0] r_op_addr, w_op_addr_nx;
    logic [DATA_LEN-1:0] r_op_data, w_op_data_nx;
    logic                r_op_is_if, w_op_is_if_nx;
    logic [23:0]         r_buf, w_buf_nx;

    logic                w_ok_if_nx, w_ok_lsb_nx, w_mem_wr_nx;
    logic [DATA_LEN-1:0] w_inst_nx, w_data_lsb_nx;
    logic [ADDR_LEN-1:0] w_mem_a_nx;
    logic [7:0]          w_mem_dout_nx;
    logic                w_start_if, w_start_lsb;

    logic                w_if_in, w_if_req;
    logic [ADDR_LEN-1:0] w_if_addr_eff;
    logic                w_lsb_in, w_lsb_keep, w_lsb_req;
    logic                w_lsb_wr_eff;
    logic [ADDR_LEN-1:0] w_lsb_addr_eff;
    logic [1:0]          w_lsb_size_eff;
    logic [DATA_LEN-1:0] w_lsb_data_eff;
    logic                w_in_io, w_io_stall, w_abort;
    logic [DATA_LEN-1:0] w_word;

    // A request arriving this cycle is visible to IDLE arbitration immediately.
    assign w_if_in       = ena_from_if & ~drop_flag_from_if;
    assign w_if_req      = (r_if_pend | ena_from_if) & ~drop_flag_from_if;
    assign w_if_addr_eff = w_if_in ? pc_from_if : r_if_addr;

    // Rollback kills loads only; stores always survive.
    assign w_lsb_in       = ena_from_lsb & ~(rollback_from_rob & ~wr_from_lsb);
    assign w_lsb_keep     = r_lsb_pend & ~(rollback_from_rob & ~r_lsb_wr);
    assign w_lsb_req      = w_lsb_keep | w_lsb_in;
    assign w_lsb_wr_eff   = w_lsb_in ? wr_from_lsb   : r_lsb_wr;
    assign w_lsb_addr_eff = w_lsb_in ? addr_from_lsb : r_lsb_addr;
    assign w_lsb_size_eff = w_lsb_in ? size_from_lsb : r_lsb_size;
    assign w_lsb_data_eff = w_lsb_in ? data_from_lsb : r_lsb_data;

    assign w_in_io = (w_lsb_addr_eff - IO_ADDR_BASE) < ADDR_LEN'(IO_WINDOW_BYTES);

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_io_stall = w_lsb_wr_eff & w_in_io & io_buffer_full;
`else
    logic w_unused_io;
    assign w_io_stall  = FALSE;
    assign w_unused_io = io_buffer_full ^ w_in_io;
`endif

    assign w_abort = r_op_is_if ? drop_flag_from_if : rollback_from_rob;

    // Final byte comes straight off mem_din in the completion cycle.
    always_comb begin
        case (r_len)
            CNT_W'(1): w_word = DATA_LEN'({24'h0, mem_din});
            CNT_W'(2): w_word = DATA_LEN'({16'h0, mem_din, r_buf[7:0]});
            default:   w_word = DATA_LEN'({mem_din, r_buf});
        endcase
    end

    // Arbitration and byte sequencing.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_len_nx      = r_len;
        w_op_addr_nx  = r_op_addr;
        w_op_data_nx  = r_op_data;
        w_op_is_if_nx = r_op_is_if;
        w_buf_nx      = r_buf;
        w_ok_if_nx    = FALSE;
        w_ok_lsb_nx   = FALSE;
        w_mem_wr_nx   = FALSE;
        w_inst_nx     = inst_to_if;
        w_data_lsb_nx = data_to_lsb;
        w_mem_a_nx    = mem_a;
        w_mem_dout_nx = mem_dout;
        w_start_if    = FALSE;
        w_start_lsb   = FALSE;

        case (r_state)
            STATUS_IDLE: begin
                if (w_lsb_req) begin
                    if (!w_io_stall) begin
                        w_start_lsb   = TRUE;
                        w_state_nx    = w_lsb_wr_eff ? STATUS_WRITE : STATUS_READ;
                        w_op_is_if_nx = FALSE;
                        w_op_addr_nx  = w_lsb_addr_eff;
                        w_op_data_nx  = w_lsb_data_eff;
                        w_len_nx      = size_to_len(w_lsb_size_eff);
                        w_cnt_nx      = CNT_W'(1);
                        w_mem_a_nx    = w_lsb_addr_eff;
                        w_mem_wr_nx   = w_lsb_wr_eff;
                        if (w_lsb_wr_eff) begin
                            w_mem_dout_nx = get_byte(32'(w_lsb_data_eff), 2'd0);
                        end
                    end
                end else if (w_if_req) begin
                    w_start_if    = TRUE;
                    w_state_nx    = STATUS_READ;
                    w_op_is_if_nx = TRUE;
                    w_op_addr_nx  = w_if_addr_eff;
                    w_len_nx      = CNT_W'(4);
                    w_cnt_nx      = CNT_W'(1);
                    w_mem_a_nx    = w_if_addr_eff;
                end
            end
            STATUS_READ: begin
                if (w_abort) begin
                    w_state_nx = STATUS_IDLE;
                end else if (r_cnt == (r_len + CNT_W'(1))) begin
                    w_state_nx = STATUS_DONE;
                    if (r_op_is_if) begin
                        w_ok_if_nx = TRUE;
                        w_inst_nx  = w_word;
                    end else begin
                        w_ok_lsb_nx   = TRUE;
                        w_data_lsb_nx = w_word;
                    end
                end else begin
                    if (r_cnt < r_len) begin
                        w_mem_a_nx = r_op_addr + ADDR_LEN'(r_cnt);
                    end
                    if (r_cnt >= CNT_W'(2)) begin
                        case (2'(r_cnt - CNT_W'(2)))
                            2'd0:    w_buf_nx[7:0]   = mem_din;
                            2'd1:    w_buf_nx[15:8]  = mem_din;
                            2'd2:    w_buf_nx[23:16] = mem_din;
                            default: w_buf_nx        = r_buf;
                        endcase
                    end
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            STATUS_WRITE: begin
                if (r_cnt < r_len) begin
                    w_mem_wr_nx   = TRUE;
                    w_mem_a_nx    = r_op_addr + ADDR_LEN'(r_cnt);
                    w_mem_dout_nx = get_byte(32'(r_op_data), r_cnt[1:0]);
                    w_cnt_nx      = r_cnt + CNT_W'(1);
                end else begin
                    w_ok_lsb_nx = TRUE;
                    w_state_nx  = STATUS_DONE;
                end
            end
            STATUS_DONE: begin
                w_state_nx = STATUS_IDLE;
            end
            default: begin
                w_state_nx = STATUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= STATUS_IDLE;
            r_cnt          <= '0;
            r_len          <= '0;
            r_op_addr      <= '0;
            r_op_data      <= '0;
            r_op_is_if     <= FALSE;
            r_buf          <= '0;
            r_if_pend      <= FALSE;
            r_if_addr      <= '0;
            r_lsb_pend     <= FALSE;
            r_lsb_wr       <= FALSE;
            r_lsb_addr     <= '0;
            r_lsb_size     <= '0;
            r_lsb_data     <= '0;
            ok_flag_to_if  <= FALSE;
            ok_flag_to_lsb <= FALSE;
            inst_to_if     <= '0;
            data_to_lsb    <= '0;
            mem_a          <= '0;
            mem_dout       <= '0;
            mem_wr         <= FALSE;
        end else if (rdy) begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            r_len          <= w_len_nx;
            r_op_addr      <= w_op_addr_nx;
            r_op_data      <= w_op_data_nx;
            r_op_is_if     <= w_op_is_if_nx;
            r_buf          <= w_buf_nx;
            r_if_pend      <= w_if_req & ~w_start_if;
            r_lsb_pend     <= w_lsb_req & ~w_start_lsb;
            if (w_if_in) begin
                r_if_addr <= pc_from_if;
            end
            if (w_lsb_in) begin
                r_lsb_wr   <= wr_from_lsb;
                r_lsb_addr <= addr_from_lsb;
                r_lsb_size <= size_from_lsb;
                r_lsb_data <= data_from_lsb;
            end
            ok_flag_to_if  <= w_ok_if_nx;
            ok_flag_to_lsb <= w_ok_lsb_nx;
            inst_to_if     <= w_inst_nx;
            data_to_lsb    <= w_data_lsb_nx;
            mem_a          <= w_mem_a_nx;
            mem_dout       <= w_mem_dout_nx;
            mem_wr         <= w_mem_wr_nx;
        end
    end

endmodule
